// File: rtl/smg_display_arbiter_if.sv
// Bus between display clients and the tube arbiter.
// req/number_in from clients; gnt/Number_Sig/busy back.
interface smg_display_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [24*N_REQ-1:0] number_in;
  logic [N_REQ-1:0]    gnt;
  logic [23:0]         Number_Sig;
  logic                busy;

  modport master (
    output req, number_in,
    input  gnt, Number_Sig, busy
  );

  modport slave (
    input  req, number_in,
    output gnt, Number_Sig, busy
  );
endinterface

// File: rtl/smg_display_arbiter.sv
// Round-robin owner of the 6-digit tube with minimum dwell.
// Ports: CLK, RST_N (sync, active-low), bus (slave modport).
module smg_display_arbiter #(
  parameter int          N_REQ        = 4,
  parameter int          DWELL_CYCLES = 50_000_000,
  parameter logic [23:0] IDLE_VALUE   = 24'd0
) (
  input logic CLK,
  input logic RST_N,
  smg_display_arbiter_if.slave bus
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam int IW = $clog2(N_REQ);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    LINGER
  } state_t;

  state_t           r_state, w_state_n;
  logic [N_REQ-1:0] r_gnt, w_gnt_n;
  logic [23:0]      r_num, w_num_n;
  logic             r_busy;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic [IW-1:0]    r_ptr, w_ptr_n;
  logic [IW-1:0]    r_own, w_own_n;
  logic [IW-1:0]    w_win;
  logic [N_REQ-1:0] w_others, w_cand;
  logic             w_done, w_own_req, w_grant;

  // First set bit at or after p, wrapping.
  function automatic logic [IW-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [IW-1:0]    p
  );
    int j;
    rr_pick = p;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (r[j]) rr_pick = IW'(j);
    end
  endfunction

  always_comb begin
    w_done    = (r_cnt == LAST);
    w_own_req = bus.req[r_own];
    w_others  = bus.req & ~(N_REQ'(1) << r_own);
    // While showing, the owner itself is never a candidate.
    w_cand    = (r_state == SHOW) ? w_others : bus.req;
    w_win     = rr_pick(w_cand, r_ptr);
    w_grant   = 1'b0;
    w_state_n = r_state;
    w_cnt_n   = w_done ? r_cnt : r_cnt + CW'(1);
    w_own_n   = r_own;
    w_ptr_n   = r_ptr;

    unique case (r_state)
      IDLE: begin
        if (|bus.req) w_grant = 1'b1;
      end
      SHOW: begin
        if (w_own_req) begin
          if (w_done && |w_others) w_grant = 1'b1;
        end else if (!w_done) begin
          w_state_n = LINGER;
        end else if (|w_others) begin
          w_grant = 1'b1;
        end else begin
          w_state_n = IDLE;
        end
      end
      LINGER: begin
        if (w_done) begin
          if (|bus.req) w_grant = 1'b1;
          else          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase

    if (w_grant) begin
      w_state_n = SHOW;
      w_own_n   = w_win;
      w_cnt_n   = '0;
      w_ptr_n   = (w_win == IW'(N_REQ - 1)) ?
                  '0 : w_win + IW'(1);
    end
    if (w_state_n == IDLE) w_cnt_n = '0;

    w_gnt_n = (w_state_n == SHOW) ?
              (N_REQ'(1) << w_own_n) : '0;

    // Value tracks the owner with one cycle of latency;
    // frozen in LINGER and on the first cycle of a new grant.
    w_num_n = r_num;
    if (w_state_n == IDLE)
      w_num_n = IDLE_VALUE;
    else if (r_state == SHOW)
      w_num_n = bus.number_in[int'(r_own)*24 +: 24];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_num   <= IDLE_VALUE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_own   <= '0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_num   <= w_num_n;
      r_busy  <= (w_state_n != IDLE);
      r_cnt   <= w_cnt_n;
      r_ptr   <= w_ptr_n;
      r_own   <= w_own_n;
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.Number_Sig = r_num;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_smg_display_arbiter.sv
// Bench for smg_display_arbiter: directed cases plus
// random req/value traffic against a behavioural model.
module tb_smg_display_arbiter;

  localparam int N = 4;
  localparam int D = 8;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  smg_display_arbiter_if #(.N_REQ(N)) bus();

  smg_display_arbiter #(
    .N_REQ(N),
    .DWELL_CYCLES(D),
    .IDLE_VALUE(24'd0)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: owner index (-1 none), lingering flag,
  // cycles since grant, RR pointer, displayed value.
  int          m_own = -1;
  bit          m_lin = 1'b0;
  int          m_age = 0;
  int          m_ptr = 0;
  logic [23:0] m_disp = 24'd0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_own = w;
    m_lin = 1'b0;
    m_age = 0;
    m_ptr = (w + 1) % N;
  endtask

  task automatic m_idle();
    m_own  = -1;
    m_lin  = 1'b0;
    m_age  = 0;
    m_disp = 24'd0;
  endtask

  task automatic m_step(input logic rn,
                        input logic [N-1:0] r,
                        input logic [24*N-1:0] nv);
    logic [N-1:0] oth;
    bit done;
    if (!rn) begin
      m_idle();
      m_ptr = 0;
      return;
    end
    done = (m_age == D - 1);
    if (m_own < 0) begin
      if (r != 0) m_grant(pick(r));
    end else if (m_lin) begin
      if (!done)       m_age++;
      else if (r != 0) m_grant(pick(r));
      else             m_idle();
    end else begin
      oth = r;
      oth[m_own] = 1'b0;
      m_disp = nv[24*m_own +: 24];
      if (r[m_own] && !(done && oth != 0)) begin
        if (!done) m_age++;
      end else if (!r[m_own] && !done) begin
        m_lin = 1'b1;
        m_age++;
      end else if (oth != 0) begin
        m_grant(pick(oth));
      end else begin
        m_idle();
      end
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    if (m_own >= 0 && !m_lin) return N'(1) << m_own;
    return '0;
  endfunction

  task automatic cyc(input logic rn,
                     input logic [N-1:0] r,
                     input logic [24*N-1:0] nv);
    RST_N = rn;
    bus.req = r;
    bus.number_in = nv;
    @(posedge CLK);
    m_step(rn, r, nv);
    #1;
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt()));
    chk("num", 32'(bus.Number_Sig), 32'(m_disp));
    chk("busy", 32'(bus.busy), 32'(m_own >= 0));
  endtask

  logic [24*N-1:0] nv;
  logic [N-1:0]    rq;
  logic            rn;

  initial begin
    nv = '0;
    bus.req = '0;
    bus.number_in = '0;

    // Reset with all requests high, then release.
    cyc(1'b0, 4'hF, nv);
    cyc(1'b0, 4'hF, nv);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_num", 32'(bus.Number_Sig), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    cyc(1'b1, 4'hF, nv);
    chk("rel_gnt", 32'(bus.gnt), 32'b0001);

    // Single owner tracking a live value.
    cyc(1'b0, 4'h0, nv);
    nv[24 +: 24] = 24'h123456;
    cyc(1'b1, 4'b0010, nv);
    chk("one_gnt", 32'(bus.gnt), 32'b0010);
    cyc(1'b1, 4'b0010, nv);
    chk("one_num", 32'(bus.Number_Sig), 32'h123456);
    nv[24 +: 24] = 24'h654321;
    cyc(1'b1, 4'b0010, nv);
    chk("chg_num", 32'(bus.Number_Sig), 32'h654321);
    for (int i = 0; i < 20; i++) cyc(1'b1, 4'b0010, nv);
    chk("hold_gnt", 32'(bus.gnt), 32'b0010);

    // Full contention: 8 cycles each, no gap.
    cyc(1'b0, 4'h0, nv);
    cyc(1'b1, 4'hF, nv);
    chk("ct_first", 32'(bus.gnt), 32'b0001);
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'hF, nv);
    chk("ct_last0", 32'(bus.gnt), 32'b0001);
    cyc(1'b1, 4'hF, nv);
    chk("ct_hand1", 32'(bus.gnt), 32'b0010);
    for (int i = 0; i < 24; i++) cyc(1'b1, 4'hF, nv);
    chk("ct_wrap0", 32'(bus.gnt), 32'b0001);

    // Early release, then a new request during linger.
    cyc(1'b0, 4'h0, nv);
    nv[0 +: 24] = 24'hABCDEF;
    cyc(1'b1, 4'b0001, nv);
    cyc(1'b1, 4'b0001, nv);
    cyc(1'b1, 4'b0001, nv);
    cyc(1'b1, 4'b0000, nv);
    chk("ln_gnt", 32'(bus.gnt), 32'd0);
    chk("ln_busy", 32'(bus.busy), 32'd1);
    chk("ln_num", 32'(bus.Number_Sig), 32'hABCDEF);
    cyc(1'b1, 4'b0000, nv);
    cyc(1'b1, 4'b0100, nv);
    cyc(1'b1, 4'b0100, nv);
    cyc(1'b1, 4'b0100, nv);
    chk("ln_wait", 32'(bus.gnt), 32'd0);
    cyc(1'b1, 4'b0100, nv);
    chk("ln_grant", 32'(bus.gnt), 32'b0100);

    // Release after dwell with nobody waiting.
    cyc(1'b0, 4'h0, nv);
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'b0010, nv);
    cyc(1'b1, 4'b0000, nv);
    chk("rel_num", 32'(bus.Number_Sig), 32'd0);
    chk("rel_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of a SHOW.
    cyc(1'b0, 4'h0, nv);
    cyc(1'b1, 4'hF, nv);
    cyc(1'b1, 4'hF, nv);
    cyc(1'b1, 4'hF, nv);
    cyc(1'b1, 4'hF, nv);
    cyc(1'b1, 4'hF, nv);
    cyc(1'b1, 4'hF, nv);
    cyc(1'b0, 4'hF, nv);
    chk("mid_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_num", 32'(bus.Number_Sig), 32'd0);
    cyc(1'b1, 4'hF, nv);
    chk("mid_ptr", 32'(bus.gnt), 32'b0001);

    // Random traffic with sticky request bits.
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      nv = {$urandom(), $urandom(), $urandom()};
      rn = ($urandom_range(0, 499) != 0);
      cyc(rn, rq, nv);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
